// File: rtl/video_pkg.sv
// Shared video timing defaults, pattern-source encodings and colour-bar palette
// used by rgb_timing_gen and rgb_pattern_lut.
package video_pkg;

  localparam int H_ACTIVE_DEF = 1280;
  localparam int H_FP_DEF     = 110;
  localparam int H_SYNC_DEF   = 40;
  localparam int H_BP_DEF     = 220;
  localparam int V_ACTIVE_DEF = 720;
  localparam int V_FP_DEF     = 5;
  localparam int V_SYNC_DEF   = 5;
  localparam int V_BP_DEF     = 20;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_RAMP    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_EXT     = 2'd3
  } pattern_e;

  localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] C_CYAN    = 24'h00FFFF;
  localparam logic [23:0] C_GREEN   = 24'h00FF00;
  localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] C_RED     = 24'hFF0000;
  localparam logic [23:0] C_BLUE    = 24'h0000FF;
  localparam logic [23:0] C_BLACK   = 24'h000000;

  // Bars run left to right in the classic SMPTE-like order.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return C_WHITE;
      3'd1:    return C_YELLOW;
      3'd2:    return C_CYAN;
      3'd3:    return C_GREEN;
      3'd4:    return C_MAGENTA;
      3'd5:    return C_RED;
      3'd6:    return C_BLUE;
      default: return C_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/rgb_pattern_lut.sv
// Combinational colour generator: maps (column, row, source select) to a
// 24-bit {R,G,B} pixel; the external source simply passes i_ext through.
module rgb_pattern_lut
  import video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF
) (
  input  logic [10:0] i_col,
  input  logic [9:0]  i_row,
  input  pattern_e    i_sel,
  input  logic [23:0] i_ext,
  output logic [23:0] o_rgb
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] w_bar_idx;
  logic       w_unused_row;

  assign w_unused_row = ^{i_row[9:6], i_row[4:0]};

  // Compare chain instead of a divider: the bar index is the last threshold crossed.
  always_comb begin
    w_bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if ({21'd0, i_col} >= 32'(k * BAR_W)) w_bar_idx = 3'(k);
    end
  end

  always_comb begin
    o_rgb = C_BLACK;
    case (i_sel)
      PAT_BARS:    o_rgb = bar_colour(w_bar_idx);
      PAT_RAMP:    o_rgb = {i_col[7:0], i_col[7:0], i_col[7:0]};
      PAT_CHECKER: o_rgb = (i_col[5] ^ i_row[5]) ? C_WHITE : C_BLACK;
      PAT_EXT:     o_rgb = i_ext;
      default:     o_rgb = C_BLACK;
    endcase
  end

endmodule

// File: rtl/rgb_timing_gen.sv
// Raster timing generator with built-in test patterns and an external pixel port.
// Optional macro RGB_TPG_SCROLL_EN adds a per-frame horizontal scroll of the built-in patterns.
module rgb_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        clk_Image_Process,
  input  logic        Rst,
  input  logic        En,
  input  logic [1:0]  Pattern_Sel,
  output logic        Ext_Req,
  input  logic [23:0] Ext_Data,
  output logic [23:0] RGB_Data_Src,
  output logic        RGB_HSync_Src,
  output logic        RGB_VSync_Src,
  output logic        RGB_VDE_Src,
  output logic [10:0] RGB_x_Src,
  output logic [9:0]  RGB_y_Src,
  output logic        Frame_Start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT        = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT        = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] r_h_cnt;
  logic [9:0]  r_v_cnt;
  pattern_e    r_sel;

  logic        w_frame_origin;
  logic        w_active;
  logic        w_hs_win;
  logic        w_vs_win;
  pattern_e    w_sel;
  logic [10:0] w_col;
  logic [23:0] w_pix;

  assign w_frame_origin = (r_h_cnt == 11'd0) && (r_v_cnt == 10'd0);
  assign w_active       = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs_win       = (r_h_cnt >= H_SYNC_START) && (r_h_cnt < H_SYNC_END);
  assign w_vs_win       = (r_v_cnt >= V_SYNC_START) && (r_v_cnt < V_SYNC_END);

  // The select sampled at the frame origin already governs pixel (0,0).
  assign w_sel   = w_frame_origin ? pattern_e'(Pattern_Sel) : r_sel;
  assign Ext_Req = Rst & En & w_active;

`ifdef RGB_TPG_SCROLL_EN
  logic [10:0] r_offset;
  logic [10:0] w_offset;
  logic [11:0] w_col_sum;

  // The offset steps at the frame origin and the stepped value covers the whole frame.
  always_comb begin
    w_offset = r_offset;
    if (w_frame_origin) w_offset = (r_offset == H_ACT - 11'd1) ? 11'd0 : r_offset + 11'd1;
    w_col_sum = {1'b0, r_h_cnt} + {1'b0, w_offset};
    w_col     = (w_col_sum >= {1'b0, H_ACT}) ? 11'(w_col_sum - {1'b0, H_ACT}) : w_col_sum[10:0];
  end

  always_ff @(posedge clk_Image_Process or negedge Rst) begin
    if (!Rst)    r_offset <= '0;
    else if (En) r_offset <= w_offset;
  end
`else
  assign w_col = r_h_cnt;
`endif

  rgb_pattern_lut #(
    .H_ACTIVE (H_ACTIVE)
  ) u_lut (
    .i_col (w_col),
    .i_row (r_v_cnt),
    .i_sel (w_sel),
    .i_ext (Ext_Data),
    .o_rgb (w_pix)
  );

  always_ff @(posedge clk_Image_Process or negedge Rst) begin
    if (!Rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_sel   <= PAT_BARS;
    end else if (!En) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_sel <= w_sel;
      if (r_h_cnt == H_LAST) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 11'd1;
      end
    end
  end

  // Every video output is the registered image of the current counter state.
  always_ff @(posedge clk_Image_Process or negedge Rst) begin
    if (!Rst) begin
      RGB_Data_Src  <= '0;
      RGB_HSync_Src <= ~HS_POL;
      RGB_VSync_Src <= ~VS_POL;
      RGB_VDE_Src   <= 1'b0;
      RGB_x_Src     <= '0;
      RGB_y_Src     <= '0;
      Frame_Start   <= 1'b0;
    end else if (!En) begin
      RGB_Data_Src  <= '0;
      RGB_HSync_Src <= ~HS_POL;
      RGB_VSync_Src <= ~VS_POL;
      RGB_VDE_Src   <= 1'b0;
      RGB_x_Src     <= '0;
      RGB_y_Src     <= '0;
      Frame_Start   <= 1'b0;
    end else begin
      RGB_Data_Src  <= w_active ? w_pix : 24'd0;
      RGB_HSync_Src <= w_hs_win ? HS_POL : ~HS_POL;
      RGB_VSync_Src <= w_vs_win ? VS_POL : ~VS_POL;
      RGB_VDE_Src   <= w_active;
      RGB_x_Src     <= w_active ? r_h_cnt : 11'd0;
      RGB_y_Src     <= w_active ? r_v_cnt : 10'd0;
      Frame_Start   <= w_frame_origin;
    end
  end

endmodule
